// File: rtl/ft232h_pll_rst_ctrl.sv
// PLL reset sequencer and lock qualifier running on the free-running reference clock.
// Holds the system in reset until the synchronized PLL lock has been stable for a full window.

package ft232h_pll_rst_ctrl_pkg;
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;
endpackage

module ft232h_pll_rst_ctrl_chk #(
    parameter int RST_CYCLES    = 24,
    parameter int LOCK_TIMEOUT  = 24000,
    parameter int STABLE_CYCLES = 240,
    parameter int TMR_W         = 16
) (
    input logic                          refclk,
    input logic                          rst,
    input ft232h_pll_rst_ctrl_pkg::state_t state,
    input logic [TMR_W-1:0]              timer,
    input logic                          pll_rst,
    input logic                          sys_rst,
    input logic                          ready
);
    import ft232h_pll_rst_ctrl_pkg::*;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO     = {TMR_W{1'b0}};

    // The timer never runs past the terminal value of the state it belongs to.
    a_timer_bound: assert property (@(posedge refclk) disable iff (rst)
        ((state == PLL_RST)   -> (timer <= RST_LAST)) &&
        ((state == WAIT_LOCK) -> (timer <= TIMEOUT_LAST)) &&
        ((state == STABLE)    -> (timer <= STABLE_LAST)) &&
        ((state == RUN)       -> (timer == TMR_ZERO)));

    a_pll_rst_implies_sys_rst: assert property (@(posedge refclk) disable iff (rst)
        pll_rst |-> sys_rst);

    a_ready_matches_run: assert property (@(posedge refclk) disable iff (rst)
        (ready == (state == RUN)) && (ready == !sys_rst));
endmodule

module ft232h_pll_rst_ctrl #(
    parameter int RST_CYCLES    = 24,
    parameter int LOCK_TIMEOUT  = 24000,
    parameter int STABLE_CYCLES = 240,
    parameter int TMR_W         = 16,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] relock_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);
    import ft232h_pll_rst_ctrl_pkg::*;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO     = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_nxt_s;
    logic               sync_meta_r;
    logic               lk_r;
    logic               timeout_hit_s;
    logic               lock_lost_s;

    // Error counters stick at full scale so a long fault history never reads back as small.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    // Two-flop synchronizer for the lock output, which is asynchronous to refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            lk_r        <= 1'b0;
        end else begin
            sync_meta_r <= pll_locked;
            lk_r        <= sync_meta_r;
        end
    end

    // Next-state and timer logic; every transition restarts the timer from zero.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        timeout_hit_s = 1'b0;
        lock_lost_s   = 1'b0;
        case (state_r)
            PLL_RST: begin
                if (timer_r == RST_LAST) begin
                    state_nxt_s = WAIT_LOCK;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the terminal cycle still wins.
                if (lk_r) begin
                    state_nxt_s = STABLE;
                    timer_nxt_s = TMR_ZERO;
                end else if (timer_r == TIMEOUT_LAST) begin
                    state_nxt_s   = PLL_RST;
                    timer_nxt_s   = TMR_ZERO;
                    timeout_hit_s = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            STABLE: begin
                if (!lk_r) begin
                    state_nxt_s = WAIT_LOCK;
                    timer_nxt_s = TMR_ZERO;
                end else if (timer_r == STABLE_LAST) begin
                    state_nxt_s = RUN;
                    timer_nxt_s = TMR_ZERO;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            RUN: begin
                if (!lk_r) begin
                    state_nxt_s = PLL_RST;
                    timer_nxt_s = TMR_ZERO;
                    lock_lost_s = 1'b1;
                end else begin
                    timer_nxt_s = TMR_ZERO;
                end
            end
            default: begin
                state_nxt_s = PLL_RST;
                timer_nxt_s = TMR_ZERO;
            end
        endcase
    end

    // State, timer, outputs and counters; outputs follow the next state so they change with it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r     <= PLL_RST;
            timer_r     <= TMR_ZERO;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            relock_cnt  <= CNT_ZERO;
            timeout_cnt <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            pll_rst     <= (state_nxt_s == PLL_RST);
            sys_rst     <= (state_nxt_s != RUN);
            ready       <= (state_nxt_s == RUN);
            relock_cnt  <= lock_lost_s   ? sat_inc(relock_cnt)  : relock_cnt;
            timeout_cnt <= timeout_hit_s ? sat_inc(timeout_cnt) : timeout_cnt;
        end
    end

    ft232h_pll_rst_ctrl_chk #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TMR_W         (TMR_W)
    ) u_chk (
        .refclk  (refclk),
        .rst     (rst),
        .state   (state_r),
        .timer   (timer_r),
        .pll_rst (pll_rst),
        .sys_rst (sys_rst),
        .ready   (ready)
    );
endmodule
